dma_transfer_sequencer: RTL and testbench

Parametrised timing-and-control sequencer for the DMA controller. It arbitrates up to NUM_CHANNELS requests with fixed or rotating priority and runs the bus-hold handshake. For each transfer cycle it generates the single-cycle control strobes the datapath consumes: load, DACK assert/deassert, count/address update and end-of-process. It adds per-channel demand, single and block modes, auto-initialisation and sticky terminal-count status.

---
 rtl/dma_transfer_sequencer_if.sv | 45 ++++
 rtl/dma_transfer_sequencer.sv | 137 +++++++++++++
 tb/tb_dma_transfer_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_transfer_sequencer_if.sv
// Purpose: request/hold handshake, per-channel mode inputs and control strobes of the DMA sequencer.
// Latency: none, this is a plain signal bundle.
// Backpressure: carried by the HRQ/HLDA hold handshake and by READY.
interface dma_transfer_sequencer_if #(
  parameter int NUM_CHANNELS = 4
);
  logic [NUM_CHANNELS-1:0]   DREQ;
  logic                      HLDA;
  logic                      READY;
  logic                      EOP_n;
  logic                      programCondition;
  logic [2*NUM_CHANNELS-1:0] modeTransfer;
  logic [NUM_CHANNELS-1:0]   autoInit;
  logic                      tcReached;
  logic                      statusRead;

  logic                      HRQ;
  logic [NUM_CHANNELS-1:0]   activeChannel;
  logic                      loadAddr;
  logic                      assertDACK;
  logic                      deassertDACK;
  logic                      intEOP;
  logic                      decrTemporaryWordCountReg;
  logic                      incrTemporaryAddressReg;
  logic                      updateCurrentWordCountReg;
  logic                      updateCurrentAddressReg;
  logic                      autoInitLoad;
  logic [NUM_CHANNELS-1:0]   tcStatus;

  // Sequencer side.
  modport master (
    input  DREQ, HLDA, READY, EOP_n, programCondition, modeTransfer, autoInit, tcReached, statusRead,
    output HRQ, activeChannel, loadAddr, assertDACK, deassertDACK, intEOP,
           decrTemporaryWordCountReg, incrTemporaryAddressReg, updateCurrentWordCountReg,
           updateCurrentAddressReg, autoInitLoad, tcStatus
  );

  // Environment side: CPU hold logic, request masking and the address/count datapath.
  modport slave (
    output DREQ, HLDA, READY, EOP_n, programCondition, modeTransfer, autoInit, tcReached, statusRead,
    input  HRQ, activeChannel, loadAddr, assertDACK, deassertDACK, intEOP,
           decrTemporaryWordCountReg, incrTemporaryAddressReg, updateCurrentWordCountReg,
           updateCurrentAddressReg, autoInitLoad, tcStatus
  );
endinterface

// File: rtl/dma_transfer_sequencer.sv
// Purpose: arbitrates DMA channel requests, runs the HRQ/HLDA hold handshake and emits per-transfer control strobes.
// Latency: HRQ one cycle after a request; loadAddr one cycle after HLDA is seen in S0; four cycles per transfer at READY=1.
// Backpressure: READY low holds S3; HLDA falling mid-service aborts back to idle with a DACK release strobe.
module dma_transfer_sequencer #(
  parameter int NUM_CHANNELS      = 4,
  parameter int ROTATING_PRIORITY = 0
) (
  input logic                 CLK,
  input logic                 RESET,
  dma_transfer_sequencer_if.master bus
);

  localparam int IDXW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  state_t                  state, nextState;
  logic [NUM_CHANNELS-1:0] activeReg, grantOh, rotReq, tcReg;
  logic [IDXW-1:0]         prioPtr, grantIdx, activeIdx, ptrNext;
  logic                    firstPass, eopSeen, abortPend, found;
  logic                    anyReq, inService, abortNow, s4Live, activeReq, eopCond, terminate;
  logic                    modeDemand, modeBlock, modeSingle;
  logic [1:0]              modeBits;
  int                      cand;

  // Per-cycle decode of the active channel's mode and the termination condition.
  always_comb begin
    anyReq    = |bus.DREQ;
    inService = state inside {S1, S2, S3, S4};
    abortNow  = inService && !bus.HLDA;
    s4Live    = (state == S4) && bus.HLDA;
    modeBits  = 2'b00;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (activeReg[i]) modeBits = bus.modeTransfer[2*i +: 2];
    end
    modeDemand = (modeBits == 2'b00);
    modeBlock  = (modeBits == 2'b10);
    modeSingle = !modeDemand && !modeBlock;
    activeReq  = |(bus.DREQ & activeReg);
    // EOP_n seen low earlier in S2/S3 of this transfer counts as well as a live one.
    eopCond    = bus.tcReached || !bus.EOP_n || eopSeen;
    terminate  = eopCond || modeSingle || (modeDemand && !activeReq);
  end

  // Priority search starting at the pointer; also the pointer value that makes the serviced channel lowest.
  always_comb begin
    rotReq   = NUM_CHANNELS'({bus.DREQ, bus.DREQ} >> prioPtr);
    grantIdx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!found && rotReq[i]) begin
        found = 1'b1;
        cand  = int'(prioPtr) + i;
        if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
        grantIdx = IDXW'(cand);
      end
    end
    grantOh   = NUM_CHANNELS'(1) << grantIdx;
    activeIdx = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (activeReg[i]) activeIdx = IDXW'(i);
    end
    ptrNext = (int'(activeIdx) + 1 >= NUM_CHANNELS) ? '0 : activeIdx + 1'b1;
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= SI;
    else        state <= nextState;
  end

  // Next-state logic; losing HLDA anywhere in S1-S4 drops straight back to idle.
  always_comb begin
    nextState = state;
    case (state)
      SI: if (anyReq && !bus.programCondition) nextState = S0;
      S0: begin
        if (!anyReq)       nextState = SI;
        else if (bus.HLDA) nextState = S1;
      end
      S1: nextState = abortNow ? SI : S2;
      S2: nextState = abortNow ? SI : S3;
      S3: begin
        if (abortNow)       nextState = SI;
        else if (bus.READY) nextState = S4;
      end
      S4: nextState = (abortNow || terminate) ? SI : S1;
      default: nextState = SI;
    endcase
  end

  // Output decode: strobes are functions of the state register, plus the S4 decision inputs.
  always_comb begin
    bus.HRQ                       = (state != SI);
    bus.activeChannel             = activeReg;
    bus.tcStatus                  = tcReg;
    bus.loadAddr                  = (state == S1);
    bus.assertDACK                = (state == S2) && firstPass;
    bus.decrTemporaryWordCountReg = s4Live;
    bus.incrTemporaryAddressReg   = s4Live;
    bus.updateCurrentWordCountReg = s4Live;
    bus.updateCurrentAddressReg   = s4Live;
    bus.intEOP                    = s4Live && eopCond;
    bus.deassertDACK              = (s4Live && terminate) || abortPend;
    bus.autoInitLoad              = s4Live && bus.tcReached && |(bus.autoInit & activeReg);
  end

  // Service bookkeeping: granted channel, first-pass DACK flag, latched EOP, abort release, priority, TC status.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      activeReg <= '0;
      firstPass <= 1'b0;
      eopSeen   <= 1'b0;
      abortPend <= 1'b0;
      prioPtr   <= '0;
      tcReg     <= '0;
    end else begin
      abortPend <= abortNow;
      if (state == S0 && anyReq && bus.HLDA) begin
        activeReg <= grantOh;
        firstPass <= 1'b1;
      end else if (abortNow || (s4Live && terminate)) begin
        activeReg <= '0;
        firstPass <= 1'b0;
      end else if (state == S2) begin
        firstPass <= 1'b0;
      end
      if ((state == S2 || state == S3) && !bus.EOP_n) eopSeen <= 1'b1;
      else if (state == S4 || state == SI)             eopSeen <= 1'b0;
      if (ROTATING_PRIORITY != 0 && s4Live && terminate) prioPtr <= ptrNext;
      // A terminal count landing in the same cycle as a status read survives the clear.
      tcReg <= (bus.statusRead ? '0 : tcReg) | ((s4Live && bus.tcReached) ? activeReg : '0);
    end
  end

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Purpose: directed self-checking bench for dma_transfer_sequencer (fixed and rotating priority instances).
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: READY and HLDA driven directly by the scenarios.
module tb_dma_transfer_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] dreq, autoIn;
  logic [7:0] mode;
  logic       hlda, ready, eopN, progCond, tcR, statusRd;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  dma_transfer_sequencer_if #(.NUM_CHANNELS(4)) busF ();
  dma_transfer_sequencer_if #(.NUM_CHANNELS(4)) busR ();

  assign busF.DREQ = dreq;        assign busR.DREQ = dreq;
  assign busF.HLDA = hlda;        assign busR.HLDA = hlda;
  assign busF.READY = ready;      assign busR.READY = ready;
  assign busF.EOP_n = eopN;       assign busR.EOP_n = eopN;
  assign busF.programCondition = progCond;  assign busR.programCondition = progCond;
  assign busF.modeTransfer = mode;          assign busR.modeTransfer = mode;
  assign busF.autoInit = autoIn;            assign busR.autoInit = autoIn;
  assign busF.tcReached = tcR;              assign busR.tcReached = tcR;
  assign busF.statusRead = statusRd;        assign busR.statusRead = statusRd;

  dma_transfer_sequencer #(.NUM_CHANNELS(4), .ROTATING_PRIORITY(0)) dutF (.CLK(clk), .RESET(rstN), .bus(busF));
  dma_transfer_sequencer #(.NUM_CHANNELS(4), .ROTATING_PRIORITY(1)) dutR (.CLK(clk), .RESET(rstN), .bus(busR));

  logic [3:0] updF, updR;
  assign updF = {busF.decrTemporaryWordCountReg, busF.incrTemporaryAddressReg,
                 busF.updateCurrentWordCountReg, busF.updateCurrentAddressReg};
  assign updR = {busR.decrTemporaryWordCountReg, busR.incrTemporaryAddressReg,
                 busR.updateCurrentWordCountReg, busR.updateCurrentAddressReg};

  // Strobe pulse counters and serviced-channel logs, sampled mid-cycle.
  int nLoad = 0, nAssert = 0, nDeassert = 0, nEop = 0, nUpd = 0, nAuto = 0;
  logic [3:0] svcF[$];
  logic [3:0] svcR[$];
  always @(negedge clk) begin
    if (busF.loadAddr)     nLoad <= nLoad + 1;
    if (busF.assertDACK)   nAssert <= nAssert + 1;
    if (busF.deassertDACK) nDeassert <= nDeassert + 1;
    if (busF.intEOP)       nEop <= nEop + 1;
    if (busF.decrTemporaryWordCountReg) nUpd <= nUpd + 1;
    if (busF.autoInitLoad) nAuto <= nAuto + 1;
    if (busF.loadAddr) svcF.push_back(busF.activeChannel);
    if (busR.loadAddr) svcR.push_back(busR.activeChannel);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic setIdle();
    dreq = 4'b0; hlda = 1'b0; ready = 1'b1; eopN = 1'b1;
    progCond = 1'b0; tcR = 1'b0; statusRd = 1'b0;
  endtask

  // Stimulus only: one single-mode transfer on req, with tcReached and optionally statusRead in S4.
  task automatic runSingleTc(input logic [3:0] req, input logic srAtS4);
    nxt(); dreq = req; hlda = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      nxt();
      if (k == 2) dreq = 4'b0;
      if (k == 5) begin tcR = 1'b1; statusRd = srAtS4; end
    end
    nxt(); tcR = 1'b0; statusRd = 1'b0; hlda = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; setIdle(); mode = 8'h00; autoIn = 4'b0;
    repeat (2) smp();
    checks++; if (busF.HRQ !== 1'b0) begin errors++; $display("FAIL reset_hrq: got %b want 0", busF.HRQ); end
    checks++; if (busF.activeChannel !== 4'b0) begin errors++; $display("FAIL reset_active: got %b want 0000", busF.activeChannel); end
    checks++; if (busF.tcStatus !== 4'b0) begin errors++; $display("FAIL reset_tc: got %b want 0000", busF.tcStatus); end
    checks++; if ({busF.loadAddr, busF.assertDACK, busF.deassertDACK, busF.intEOP, busF.autoInitLoad, updF} !== 9'b0)
      begin errors++; $display("FAIL reset_strobes: got %b want 0", {busF.loadAddr, busF.assertDACK, busF.deassertDACK, busF.intEOP, busF.autoInitLoad, updF}); end
    checks++; if ({busR.HRQ, busR.activeChannel, busR.tcStatus, busR.loadAddr, busR.assertDACK, busR.deassertDACK,
                   busR.intEOP, busR.autoInitLoad, updR} !== 18'b0)
      begin errors++; $display("FAIL reset_rot_outputs: got %b want 0", {busR.HRQ, busR.activeChannel, busR.tcStatus}); end
    nxt(); rstN = 1'b1;
    smp();
    checks++; if ({busF.HRQ, busF.loadAddr, busF.deassertDACK} !== 3'b0) begin errors++; $display("FAIL reset_release: got %b want 000", {busF.HRQ, busF.loadAddr, busF.deassertDACK}); end
  endtask

  task automatic test_program_condition();
    nxt(); progCond = 1'b1; dreq = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      nxt(); smp();
      checks++; if (busF.HRQ !== 1'b0) begin errors++; $display("FAIL prog_blocks_hrq: cycle %0d got %b want 0", k, busF.HRQ); end
    end
    nxt(); progCond = 1'b0; dreq = 4'b0;
  endtask

  task automatic test_single();
    nxt(); mode = 8'h10; dreq = 4'b0100;
    smp();
    checks++; if (busF.HRQ !== 1'b0) begin errors++; $display("FAIL single_hrq_idle: got %b want 0", busF.HRQ); end
    nxt(); hlda = 1'b1; smp();  // S0
    checks++; if ({busF.HRQ, busF.loadAddr} !== 2'b10) begin errors++; $display("FAIL single_s0: hrq,load got %b want 10", {busF.HRQ, busF.loadAddr}); end
    nxt(); smp();               // S1
    checks++; if ({busF.loadAddr, busF.assertDACK} !== 2'b10) begin errors++; $display("FAIL single_s1_load: got %b want 10", {busF.loadAddr, busF.assertDACK}); end
    checks++; if (busF.activeChannel !== 4'b0100) begin errors++; $display("FAIL single_active: got %b want 0100", busF.activeChannel); end
    nxt(); dreq = 4'b0; smp();  // S2
    checks++; if ({busF.loadAddr, busF.assertDACK} !== 2'b01) begin errors++; $display("FAIL single_s2_dack: got %b want 01", {busF.loadAddr, busF.assertDACK}); end
    nxt(); smp();               // S3
    checks++; if ({busF.assertDACK, updF} !== 5'b0) begin errors++; $display("FAIL single_s3_quiet: got %b want 0", {busF.assertDACK, updF}); end
    nxt(); smp();               // S4
    checks++; if (updF !== 4'hF) begin errors++; $display("FAIL single_s4_upd: got %b want 1111", updF); end
    checks++; if ({busF.HRQ, busF.deassertDACK, busF.intEOP} !== 3'b110) begin errors++; $display("FAIL single_s4_term: hrq,deassert,eop got %b want 110", {busF.HRQ, busF.deassertDACK, busF.intEOP}); end
    nxt(); hlda = 1'b0; smp();  // SI
    checks++; if ({busF.HRQ, busF.activeChannel, busF.deassertDACK, updF} !== 10'b0) begin errors++; $display("FAIL single_idle_after: got %b want 0", {busF.HRQ, busF.activeChannel, busF.deassertDACK, updF}); end
  endtask

  task automatic test_block_autoinit();
    int l0, a0, d0, e0, u0, x0;
    l0 = nLoad; a0 = nAssert; d0 = nDeassert; e0 = nEop; u0 = nUpd; x0 = nAuto;
    nxt(); mode = 8'h02; autoIn = 4'b0001; dreq = 4'b0001; hlda = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      nxt();
      if (k == 2) dreq = 4'b0;
      tcR = (k == 13);
      smp();
      if (k == 9) begin
        checks++; if ({busF.deassertDACK, busF.intEOP} !== 2'b00) begin errors++; $display("FAIL block_mid_s4: deassert,eop got %b want 00", {busF.deassertDACK, busF.intEOP}); end
      end
      if (k == 13) begin
        checks++; if ({busF.intEOP, busF.deassertDACK, busF.autoInitLoad} !== 3'b111) begin errors++; $display("FAIL block_tc_s4: eop,deassert,autoinit got %b want 111", {busF.intEOP, busF.deassertDACK, busF.autoInitLoad}); end
      end
    end
    nxt(); tcR = 1'b0; hlda = 1'b0; smp();
    checks++; if (busF.tcStatus !== 4'b0001) begin errors++; $display("FAIL block_tcstatus: got %b want 0001", busF.tcStatus); end
    checks++; if (busF.HRQ !== 1'b0) begin errors++; $display("FAIL block_hrq_drop: got %b want 0", busF.HRQ); end
    checks++; if (nLoad - l0 !== 3 || nAssert - a0 !== 1 || nUpd - u0 !== 3)
      begin errors++; $display("FAIL block_counts: load %0d dack %0d upd %0d want 3 1 3", nLoad - l0, nAssert - a0, nUpd - u0); end
    checks++; if (nEop - e0 !== 1 || nDeassert - d0 !== 1 || nAuto - x0 !== 1)
      begin errors++; $display("FAIL block_end_counts: eop %0d deassert %0d autoinit %0d want 1 1 1", nEop - e0, nDeassert - d0, nAuto - x0); end
    autoIn = 4'b0;
  endtask

  task automatic test_demand();
    int l0, e0, u0;
    l0 = nLoad; e0 = nEop; u0 = nUpd;
    nxt(); mode = 8'h00; dreq = 4'b0010; hlda = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      nxt();
      if (k == 9) dreq = 4'b0;
      smp();
      if (k == 9) begin
        checks++; if ({busF.deassertDACK, busF.intEOP} !== 2'b10) begin errors++; $display("FAIL demand_drop_s4: deassert,eop got %b want 10", {busF.deassertDACK, busF.intEOP}); end
      end
    end
    nxt(); hlda = 1'b0; smp();
    checks++; if (nUpd - u0 !== 2 || nLoad - l0 !== 2 || nEop - e0 !== 0)
      begin errors++; $display("FAIL demand_counts: upd %0d load %0d eop %0d want 2 2 0", nUpd - u0, nLoad - l0, nEop - e0); end
    checks++; if ({busF.HRQ, busF.tcStatus} !== 5'b00001) begin errors++; $display("FAIL demand_after: hrq,tc got %b want 00001", {busF.HRQ, busF.tcStatus}); end
  endtask

  task automatic test_ready_wait();
    nxt(); mode = 8'h10; dreq = 4'b0100; hlda = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      nxt();
      if (k == 3) dreq = 4'b0;
      ready = !(k >= 4 && k <= 6);
      smp();
      checks++; if (busF.decrTemporaryWordCountReg !== (k == 8)) begin errors++; $display("FAIL ready_wait_s4: cycle %0d got %b want %b", k, busF.decrTemporaryWordCountReg, (k == 8)); end
    end
    nxt(); hlda = 1'b0; ready = 1'b1;
  endtask

  task automatic test_eop();
    nxt(); mode = 8'h02; dreq = 4'b0001; hlda = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      nxt();
      if (k == 2) dreq = 4'b0;
      eopN = (k != 4);
      smp();
      if (k == 5) begin
        checks++; if ({busF.intEOP, busF.deassertDACK, updF} !== 6'b111111) begin errors++; $display("FAIL eop_s4: eop,deassert,upd got %b want 111111", {busF.intEOP, busF.deassertDACK, updF}); end
      end
      if (k == 6) begin
        checks++; if ({busF.HRQ, busF.tcStatus} !== 5'b00001) begin errors++; $display("FAIL eop_after: hrq,tc got %b want 00001", {busF.HRQ, busF.tcStatus}); end
      end
    end
    nxt(); hlda = 1'b0;
  endtask

  task automatic test_abort();
    int u0, e0;
    u0 = nUpd; e0 = nEop;
    nxt(); mode = 8'h80; dreq = 4'b1000; hlda = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      nxt();
      if (k == 2) dreq = 4'b0;
      if (k == 4) hlda = 1'b0;
      smp();
      if (k == 4) begin
        checks++; if ({busF.deassertDACK, busF.activeChannel} !== 5'b01000) begin errors++; $display("FAIL abort_s3: deassert,active got %b want 01000", {busF.deassertDACK, busF.activeChannel}); end
      end
      if (k == 5) begin
        checks++; if ({busF.deassertDACK, busF.HRQ, busF.activeChannel} !== 6'b100000) begin errors++; $display("FAIL abort_release: deassert,hrq,active got %b want 100000", {busF.deassertDACK, busF.HRQ, busF.activeChannel}); end
      end
      if (k == 6) begin
        checks++; if (busF.deassertDACK !== 1'b0) begin errors++; $display("FAIL abort_one_cycle: got %b want 0", busF.deassertDACK); end
      end
    end
    checks++; if (nUpd - u0 !== 0 || nEop - e0 !== 0 || busF.tcStatus !== 4'b0001)
      begin errors++; $display("FAIL abort_side_effects: upd %0d eop %0d tc %b want 0 0 0001", nUpd - u0, nEop - e0, busF.tcStatus); end
  endtask

  task automatic test_status_read();
    nxt(); statusRd = 1'b1;
    nxt(); statusRd = 1'b0; smp();
    checks++; if (busF.tcStatus !== 4'b0000) begin errors++; $display("FAIL status_clear: got %b want 0000", busF.tcStatus); end
    mode = 8'h05;
    runSingleTc(4'b0010, 1'b0);
    smp();
    checks++; if (busF.tcStatus !== 4'b0010) begin errors++; $display("FAIL status_tc_ch1: got %b want 0010", busF.tcStatus); end
    runSingleTc(4'b0001, 1'b1);
    smp();
    checks++; if (busF.tcStatus !== 4'b0001) begin errors++; $display("FAIL status_read_vs_tc: got %b want 0001", busF.tcStatus); end
  endtask

  task automatic test_priority();
    int f0, r0;
    logic [3:0] expR [4];
    expR = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    nxt(); rstN = 1'b0;
    nxt(); rstN = 1'b1;
    f0 = svcF.size(); r0 = svcR.size();
    nxt(); mode = 8'h55; dreq = 4'b1111; hlda = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      nxt();
      if (k == 21) dreq = 4'b0;
    end
    repeat (6) nxt();
    hlda = 1'b0;
    smp();
    checks++; if (svcF.size() - f0 < 3) begin errors++; $display("FAIL prio_fixed_count: got %0d services want >=3", svcF.size() - f0); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (svcF[f0 + i] !== 4'b0001) begin errors++; $display("FAIL prio_fixed_order: service %0d got %b want 0001", i, svcF[f0 + i]); end
      end
    end
    checks++; if (svcR.size() - r0 !== 4) begin errors++; $display("FAIL prio_rot_count: got %0d services want 4", svcR.size() - r0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (svcR[r0 + i] !== expR[i]) begin errors++; $display("FAIL prio_rot_order: service %0d got %b want %b", i, svcR[r0 + i], expR[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int l0, d0, u0;
    runSingleTc(4'b0100, 1'b0);  // leaves tcStatus non-zero so the reset clear is visible
    nxt(); mode = 8'h10; dreq = 4'b0100; hlda = 1'b1;
    for (int k = 1; k <= 3; k++) begin nxt(); smp(); end
    checks++; if (busF.assertDACK !== 1'b1) begin errors++; $display("FAIL resetmid_in_s2: dack got %b want 1", busF.assertDACK); end
    #1 rstN = 1'b0;
    #1;
    checks++; if ({busF.HRQ, busF.activeChannel, busF.tcStatus, busF.loadAddr, busF.assertDACK, busF.deassertDACK, updF} !== 16'b0)
      begin errors++; $display("FAIL resetmid_outputs: got %b want 0", {busF.HRQ, busF.activeChannel, busF.tcStatus, busF.loadAddr, busF.assertDACK, busF.deassertDACK, updF}); end
    dreq = 4'b0; hlda = 1'b0;
    nxt(); nxt(); rstN = 1'b1;
    l0 = nLoad; d0 = nDeassert; u0 = nUpd;
    repeat (3) nxt();
    smp();
    checks++; if (nLoad - l0 !== 0 || nDeassert - d0 !== 0 || nUpd - u0 !== 0 || busF.HRQ !== 1'b0)
      begin errors++; $display("FAIL resetmid_release: load %0d deassert %0d upd %0d hrq %b want 0 0 0 0", nLoad - l0, nDeassert - d0, nUpd - u0, busF.HRQ); end
  endtask

  initial begin
    test_reset();
    test_program_condition();
    test_single();
    test_block_autoinit();
    test_demand();
    test_ready_wait();
    test_eop();
    test_abort();
    test_status_read();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
